serial_addsub: RTL and testbench

//  Bit-serial add/subtract engine. It drives operand bits LSB-first into a
//  one-bit full-adder cell and registers the carry between cycles.
//  It shifts the sum bits back into a result word.
//  It sits upstream of the 1-bit adder cell, feeding it a/b/cin each cycle and

---
 rtl/serial_arith_pkg.sv | 15 +
 rtl/serial_addsub_if.sv | 29 ++
 rtl/fa_bit_cell.sv | 26 ++
 rtl/serial_addsub.sv | 113 +++++++++++
 tb/tb_serial_addsub.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared state encoding and sizing helper for bit-serial arithmetic
// Purpose: state encoding for the bit-serial FSMs and a counter sizing function.
// Ports: none (package).
package serial_arith_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter width for a bit index 0..w-1; never narrower than one bit.
    function automatic int clog2_min1(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// rtl/serial_addsub_if.sv - operand/result handshake bundle for serial_addsub
// Purpose: groups the operand request channel and the result channel.
// Ports (signals):
//   in_valid/in_ready, a, b, sub        operand channel (master -> slave)
//   out_valid/out_ready, result, cout, ovf  result channel (slave -> master)
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );
endinterface

// File: rtl/fa_bit_cell.sv
// rtl/fa_bit_cell.sv - combinational one-bit full adder
// Purpose: sum/carry of a + b + cin, built as two half-adder stages plus an OR.
// Ports:
//   a, b, cin  in   operand bits and carry in
//   sum, cout  out  sum bit and carry out
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic ha0_sum;
    logic ha0_carry;
    logic ha1_carry;

    // first half adder: a + b
    assign ha0_sum   = a ^ b;
    assign ha0_carry = a & b;

    // second half adder: (a ^ b) + cin
    assign sum       = ha0_sum ^ cin;
    assign ha1_carry = ha0_sum & cin;

    assign cout      = ha0_carry | ha1_carry;
endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial add/subtract engine, one bit per cycle
// Purpose: accepts A, B and sub, streams LSB-first through one full-adder cell,
//          and presents result/cout/ovf after WIDTH cycles until taken.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of serial_addsub_if (operand and result channels)
module serial_addsub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_addsub_if.slave  bus
);
    localparam int            CW   = clog2_min1(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic             ovf_r;
    logic [CW-1:0]    cnt;
    logic             cell_sum;
    logic             cell_cout;
    logic             in_ready_c;
    logic             out_valid_c;
    logic             accept;
    logic             last_bit;

    assign last_bit = (cnt == LAST);
    assign accept   = bus.in_valid & bus.in_ready;

    fa_bit_cell u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (cell_sum),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = S_RUN;
            S_RUN:   if (last_bit) state_nx = S_DONE;
            S_DONE:  if (bus.out_ready) state_nx = bus.in_valid ? S_RUN : S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            S_IDLE: in_ready_c = 1'b1;
            S_DONE: begin
                out_valid_c = 1'b1;
                // result leaves on the same edge the next operands arrive
                in_ready_c  = bus.out_ready;
            end
            default: ;
        endcase
    end

    // in_ready is masked while reset is held so every output reads 0 then
    assign bus.in_ready  = rst_n & in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = res_sh;
    assign bus.cout      = carry;
    assign bus.ovf       = ovf_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            // subtraction is A + ~B + 1: invert B and seed the carry with 1
            a_sh  <= bus.a;
            b_sh  <= bus.sub ? ~bus.b : bus.b;
            carry <= bus.sub;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            res_sh <= {cell_sum, res_sh[WIDTH-1:1]};
            carry  <= cell_cout;
            if (last_bit) begin
                // carry into MSB is the held carry; carry out is the cell's
                ovf_r <= carry ^ cell_cout;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub (WIDTH=8)
module tb_serial_addsub;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    serial_addsub_if #(.WIDTH(8)) bus ();

    serial_addsub #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, cout, result} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y, input logic s);
        int         sx;
        int         sy;
        int         r;
        logic       o;
        logic       c;
        logic [7:0] res;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = s ? (sx - sy) : (sx + sy);
        o  = (r > 127) || (r < -128);
        if (s) begin
            res = x - y;
            c   = (x >= y);
        end else begin
            res = x + y;
            c   = (int'(x) + int'(y)) > 255;
        end
        return {o, c, res};
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic ok;
        ok = 1'b0;
        bus.a = x;
        bus.b = y;
        bus.sub = s;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        // operands must have been captured; scramble the inputs
        bus.a = 8'($urandom);
        bus.b = 8'($urandom);
        bus.sub = 1'($urandom_range(0, 1));
        check("send_accept", 32'(ok), 32'd1);
    endtask

    // Called at a negedge; waits for and takes one result.
    task automatic collect(input string tag, input logic [9:0] exp, input bit rnd_bp);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            bus.out_ready = rnd_bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                check({tag, "_result"}, 32'(bus.result), 32'(exp[7:0]));
                check({tag, "_cout"},   32'(bus.cout),   32'(exp[8]));
                check({tag, "_ovf"},    32'(bus.ovf),    32'(exp[9]));
                got = 1'b1;
                @(posedge clk);
                @(negedge clk);
                bus.out_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(got), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_result"},    32'(bus.result),    32'd0);
        check({tag, "_cout"},      32'(bus.cout),      32'd0);
        check({tag, "_ovf"},       32'(bus.ovf),       32'd0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  32'd0);
    endtask

    initial begin
        int         n;
        logic [7:0] x;
        logic [7:0] y;
        logic       s;
        logic [7:0] held;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        #3;
        check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        // 1: basic add and latency
        send(8'h35, 8'h4A, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd8);
        collect("add_35_4a", {1'b0, 1'b0, 8'h7F}, 1'b0);

        // 2: signed overflow and unsigned wrap
        send(8'h7F, 8'h01, 1'b0);
        collect("add_7f_01", {1'b1, 1'b0, 8'h80}, 1'b0);
        send(8'hFF, 8'h01, 1'b0);
        collect("add_ff_01", {1'b0, 1'b1, 8'h00}, 1'b0);

        // 3: subtraction, borrow and overflow
        send(8'h10, 8'h20, 1'b1);
        collect("sub_10_20", {1'b0, 1'b0, 8'hF0}, 1'b0);
        send(8'h80, 8'h01, 1'b1);
        collect("sub_80_01", {1'b1, 1'b1, 8'h7F}, 1'b0);

        // 4: backpressure in DONE then zero-bubble back-to-back
        send(8'h12, 8'h34, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = bus.result;
        check("bp_first_result", 32'(held), 32'h46);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result_held", 32'(bus.result), 32'(held));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.a = 8'h7F;
        bus.b = 8'h01;
        bus.sub = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        check("b2b_result_taken", 32'(bus.result), 32'h46);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("b2b_running_out_valid", 32'(bus.out_valid), 32'd0);
        check("b2b_running_in_ready", 32'(bus.in_ready), 32'd0);
        collect("b2b_add_7f_01", model(8'h7F, 8'h01, 1'b0), 1'b0);

        // 5: in_valid with changing operands during RUN is ignored
        send(8'hC3, 8'h5A, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            bus.sub = 1'($urandom_range(0, 1));
            bus.in_valid = 1'($urandom_range(0, 1));
            #1;
            check("run_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        collect("run_ignore", model(8'hC3, 8'h5A, 1'b1), 1'b0);

        // 6: asynchronous reset mid-operation
        send(8'hAA, 8'h55, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_release_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        send(8'h01, 8'h01, 1'b0);
        collect("after_abort", {1'b0, 1'b0, 8'h02}, 1'b0);

        // random operations with random backpressure
        for (int k = 0; k < 1000; k++) begin
            x = 8'($urandom);
            y = 8'($urandom);
            s = 1'($urandom_range(0, 1));
            send(x, y, s);
            collect("rand", model(x, y, s), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
